axi_burst_sram: RTL
===================

# axi_burst_sram

Parametrised AXI4 slave memory that succeeds the single-beat simulation SRAM. It holds its own word array and supports INCR bursts, byte strobes, and independent concurrent read and write channels. Read and write latencies are configurable, and out-of-range or unsupported requests return error responses. It sits behind the core/crossbar as the main memory or scratchpad target in simulation and FPGA builds.

## Interface
- BASE_ADDR, 32'h8000_0000, first byte address decoded by the block
- DEPTH, 4096, number of DATA_W-bit words; must be a power of two
- DATA_W, 32, data width; must be 32 or 64
- RD_LAT, 1, cycles from AR handshake to first rvalid; must be ≥1
- WR_LAT, 1, cycles from last W handshake to bvalid; must be ≥1
- MAX_LEN, 255, largest accepted arlen/awlen; larger values get SLVERR
- clock  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all control state
- axi  slave  ysyx_24080006_axi  uses AW, W, B, AR and R channel signals, including len/size/burst, wstrb, wlast, rlast and resp

## Operation
- Address decode: a request is in range when BASE_ADDR ≤ addr < BASE_ADDR + DEPTH·DATA_W/8.
- Word index = (addr − BASE_ADDR) >> log2(DATA_W/8). Low address bits are ignored (aligned down).
- Burst types:
  - INCR (2'b01): index +1 per beat.
  - FIXED (2'b00): same index every beat.
  - WRAP (2'b10) and 2'b11: SLVERR on every beat, no memory access.
- len > MAX_LEN: SLVERR, no memory access, but the full len+1 beats are still transferred.
- Out of range: DECERR (2'b11) on every beat. Reads return 0 and writes are dropped.
- A burst that starts in range but whose index exceeds DEPTH−1 wraps modulo DEPTH. It gets no error.
- Read FSM:
  - R_IDLE: arready=1. On arvalid, latch addr/len/burst/error and go to R_WAIT.
  - R_WAIT: count RD_LAT−1 cycles. When RD_LAT=1 it is skipped and the FSM goes straight to R_DATA.
  - R_DATA: rvalid=1, rdata = mem[index], rresp = latched error, rlast=1 on beat len.
    - On rready, advance the index and the beat counter.
    - After the last beat, go to R_IDLE.
- Write FSM:
  - W_IDLE: awready=1, wready=0. On awvalid, latch the request and go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes byte lane i of mem[index] when wstrb[i]=1 (no error only).
    - After beat len is accepted, go to W_WAIT regardless of wlast.
    - If wlast disagrees with the beat count on any beat, bresp becomes SLVERR; stored bytes are kept.
  - W_WAIT: count WR_LAT−1 cycles.
  - W_RESP: bvalid=1 with bresp. On bready, go to W_IDLE.
- Priority order for bresp: DECERR > SLVERR > OKAY.
- Same-cycle read beat and write beat to the same word: the read returns the pre-write contents. The write is visible from the next cycle.
- Reset mid-burst: both FSMs abort to IDLE immediately. Memory contents are retained, and no partial response is issued.

## Timing
- Reset values: arready=1, awready=1, wready=0, rvalid=0, rlast=0, rdata=0, rresp=2'b00, bvalid=0, bresp=2'b00.
- AR handshake in cycle t: rvalid rises at edge t+RD_LAT.
- With rready held high, beats stream one per cycle with no bubbles.
- arready is low from t+1 and returns high in the cycle after the last R handshake. The next AR is accepted no earlier than that cycle.
- The AW handshake cycle raises wready in the next cycle. W beats presented before then wait.
- Last W handshake in cycle u: bvalid rises at edge u+WR_LAT.
- awready returns high the cycle after the B handshake.
- rdata, rresp and rlast stay stable while rvalid=1 and rready=0.
- bresp stays stable while bvalid=1 and bready=0.
- The read and write channels never stall each other.

## Test plan
- Single write then read: AW 0x8000_0010, wdata 0xDEAD_BEEF, wstrb 0xF, then AR 0x8000_0010 → bresp 00, rdata 0xDEAD_BEEF, rlast=1, rvalid exactly RD_LAT cycles after AR.
- INCR write of 4 beats (0x11..0x44) at 0x8000_0100, then INCR read with len=3 and rready toggling 1,0,1,1 → data 0x11,0x22,0x33,0x44 in order, rlast only on the 4th beat, rdata stable during the stall.
- Byte strobes: write 0xFFFF_FFFF, then 0x0000_00AB with wstrb=4'b0001 → read returns 0xFFFF_FFAB.
- Errors:
  - AR 0x7FFF_FFFC with len=1 → two beats of rdata 0, rresp 11.
  - AW with burst=WRAP → bresp 10 and memory unchanged.
  - wlast early on beat 0 of len=1 → bresp 10 after the 2nd beat.
- Concurrency: a long read burst and a write burst to other addresses issued together → both complete with no inserted stall cycles.
- Same-word collision: read returns the old value.
- Reset asserted mid-burst: all outputs return to reset values without waiting for a clock edge, and a new burst after reset completes normally.

Source files
------------

// File: rtl/axi_burst_sram.sv
// AXI4 slave SRAM: INCR/FIXED bursts, byte strobes, configurable read/write latency.
// Read and write channels are independent FSMs sharing one byte-lane memory array.

module axi_burst_sram #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          DATA_W    = 32,
    parameter int          RD_LAT    = 1,
    parameter int          WR_LAT    = 1,
    parameter int          MAX_LEN   = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                awvalid,
    output logic                awready,
    input  logic [31:0]         awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [31:0]         araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast
);

    localparam int          STRB_W    = DATA_W / 8;
    localparam int          OFF_W     = $clog2(STRB_W);
    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(64'(DEPTH) * 64'(STRB_W));
    localparam logic [8:0]  MAX_LEN9  = 9'(MAX_LEN);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

    // Size is not used: every beat transfers a full word.
    logic unused_size;
    assign unused_size = ^{awsize, arsize};

    // Request decode for both address channels
    logic [32:0]      ar_off, aw_off;
    logic [IDX_W-1:0] ar_idx, aw_idx;
    logic [1:0]       ar_resp, aw_resp;

    always_comb begin
        ar_off = {1'b0, araddr} - {1'b0, BASE_ADDR};
        ar_idx = ar_off[OFF_W +: IDX_W];
        if (ar_off[32] || ar_off >= MEM_BYTES)
            ar_resp = RESP_DECERR;
        else if (arburst[1] || {1'b0, arlen} > MAX_LEN9)
            ar_resp = RESP_SLVERR;
        else
            ar_resp = RESP_OKAY;
    end

    always_comb begin
        aw_off = {1'b0, awaddr} - {1'b0, BASE_ADDR};
        aw_idx = aw_off[OFF_W +: IDX_W];
        if (aw_off[32] || aw_off >= MEM_BYTES)
            aw_resp = RESP_DECERR;
        else if (awburst[1] || {1'b0, awlen} > MAX_LEN9)
            aw_resp = RESP_SLVERR;
        else
            aw_resp = RESP_OKAY;
    end

    // Read channel state
    r_state_t         r_state_reg;
    logic [15:0]      r_cnt_reg;
    logic [7:0]       r_beat_reg, r_len_reg;
    logic [IDX_W-1:0] r_idx_reg;
    logic             r_fixed_reg;
    logic             r_last_beat;
    logic [IDX_W-1:0] r_next_idx;
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;

    assign r_last_beat = (r_beat_reg == r_len_reg);
    assign r_next_idx  = r_fixed_reg ? r_idx_reg : r_idx_reg + IDX_W'(1);

    // The memory is read on the edge a beat becomes visible, so a write on that
    // same edge is not seen by the beat (read-before-write).
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = r_next_idx;
        case (r_state_reg)
            R_IDLE: begin
                rd_en   = arvalid && arready && (RD_LAT == 1);
                rd_addr = ar_idx;
            end
            R_WAIT: begin
                rd_en   = (r_cnt_reg == 16'd0);
                rd_addr = r_idx_reg;
            end
            R_DATA: begin
                rd_en   = rready && !r_last_beat;
                rd_addr = r_next_idx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_reg <= R_IDLE;
            r_cnt_reg   <= 16'd0;
            r_beat_reg  <= 8'd0;
            r_len_reg   <= 8'd0;
            r_idx_reg   <= '0;
            r_fixed_reg <= 1'b0;
            arready     <= 1'b1;
            rvalid      <= 1'b0;
            rlast       <= 1'b0;
            rresp       <= RESP_OKAY;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        arready     <= 1'b0;
                        r_len_reg   <= arlen;
                        r_beat_reg  <= 8'd0;
                        r_idx_reg   <= ar_idx;
                        r_fixed_reg <= (arburst == 2'b00);
                        rresp       <= ar_resp;
                        if (RD_LAT == 1) begin
                            r_state_reg <= R_DATA;
                            rvalid      <= 1'b1;
                            rlast       <= (arlen == 8'd0);
                        end else begin
                            r_state_reg <= R_WAIT;
                            r_cnt_reg   <= 16'(RD_LAT - 2);
                        end
                    end
                end
                R_WAIT: begin
                    if (r_cnt_reg == 16'd0) begin
                        r_state_reg <= R_DATA;
                        rvalid      <= 1'b1;
                        rlast       <= (r_len_reg == 8'd0);
                    end else begin
                        r_cnt_reg <= r_cnt_reg - 16'd1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (r_last_beat) begin
                            r_state_reg <= R_IDLE;
                            rvalid      <= 1'b0;
                            rlast       <= 1'b0;
                            arready     <= 1'b1;
                        end else begin
                            r_beat_reg <= r_beat_reg + 8'd1;
                            r_idx_reg  <= r_next_idx;
                            rlast      <= (r_beat_reg + 8'd1 == r_len_reg);
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // Error beats and idle cycles present zero data
    assign rdata = (rvalid && rresp == RESP_OKAY) ? rd_word : '0;

    // Write channel state
    w_state_t         w_state_reg;
    logic [15:0]      w_cnt_reg;
    logic [7:0]       w_beat_reg, w_len_reg;
    logic [IDX_W-1:0] w_idx_reg;
    logic             w_fixed_reg;
    logic [1:0]       w_err_reg;
    logic             w_bad_reg;
    logic             w_last_beat;
    logic             w_bad_next;
    logic [1:0]       w_resp_next;
    logic [IDX_W-1:0] w_next_idx;
    logic             mem_we;

    assign w_last_beat = (w_beat_reg == w_len_reg);
    assign w_next_idx  = w_fixed_reg ? w_idx_reg : w_idx_reg + IDX_W'(1);
    assign w_bad_next  = w_bad_reg || (wlast != w_last_beat);
    assign w_resp_next = (w_err_reg == RESP_DECERR) ? RESP_DECERR :
                         ((w_err_reg == RESP_SLVERR) || w_bad_next) ? RESP_SLVERR : RESP_OKAY;
    assign mem_we      = (w_state_reg == W_DATA) && wvalid && (w_err_reg == RESP_OKAY);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state_reg <= W_IDLE;
            w_cnt_reg   <= 16'd0;
            w_beat_reg  <= 8'd0;
            w_len_reg   <= 8'd0;
            w_idx_reg   <= '0;
            w_fixed_reg <= 1'b0;
            w_err_reg   <= RESP_OKAY;
            w_bad_reg   <= 1'b0;
            awready     <= 1'b1;
            wready      <= 1'b0;
            bvalid      <= 1'b0;
            bresp       <= RESP_OKAY;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_state_reg <= W_DATA;
                        awready     <= 1'b0;
                        wready      <= 1'b1;
                        w_len_reg   <= awlen;
                        w_beat_reg  <= 8'd0;
                        w_idx_reg   <= aw_idx;
                        w_fixed_reg <= (awburst == 2'b00);
                        w_err_reg   <= aw_resp;
                        w_bad_reg   <= 1'b0;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        w_bad_reg <= w_bad_next;
                        if (w_last_beat) begin
                            wready <= 1'b0;
                            bresp  <= w_resp_next;
                            if (WR_LAT == 1) begin
                                w_state_reg <= W_RESP;
                                bvalid      <= 1'b1;
                            end else begin
                                w_state_reg <= W_WAIT;
                                w_cnt_reg   <= 16'(WR_LAT - 2);
                            end
                        end else begin
                            w_beat_reg <= w_beat_reg + 8'd1;
                            w_idx_reg  <= w_next_idx;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_cnt_reg == 16'd0) begin
                        w_state_reg <= W_RESP;
                        bvalid      <= 1'b1;
                    end else begin
                        w_cnt_reg <= w_cnt_reg - 16'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state_reg <= W_IDLE;
                        bvalid      <= 1'b0;
                        awready     <= 1'b1;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // One byte-wide array per strobe lane; contents survive reset.
    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clock) begin
                if (mem_we && wstrb[gi])
                    mem_lane[w_idx_reg] <= wdata[gi*8 +: 8];
                if (rd_en)
                    rd_byte_reg <= mem_lane[rd_addr];
            end

            assign rd_word[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

endmodule
